// File: rtl/mult_pkg.sv
// mult_pkg -- shared definitions for the radix-4 Booth multiplier.
//   state_t     : controller states (IDLE / EXEC / DONE), 2-bit encoded
//   booth_sel_t : recoded digit as {neg, zero, two} select bits
//   BOOTH_*     : select patterns for the digits -2 .. +2
//   num_iter()  : number of Booth digits (iterations) for an operand width
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic neg;   // subtract the partial product
        logic zero;  // digit is 0, partial product suppressed
        logic two;   // magnitude 2 (multiplicand shifted left by one)
    } booth_sel_t;

    localparam booth_sel_t BOOTH_Z  = '{neg: 1'b0, zero: 1'b1, two: 1'b0};
    localparam booth_sel_t BOOTH_P1 = '{neg: 1'b0, zero: 1'b0, two: 1'b0};
    localparam booth_sel_t BOOTH_P2 = '{neg: 1'b0, zero: 1'b0, two: 1'b1};
    localparam booth_sel_t BOOTH_M1 = '{neg: 1'b1, zero: 1'b0, two: 1'b0};
    localparam booth_sel_t BOOTH_M2 = '{neg: 1'b1, zero: 1'b0, two: 1'b1};

    // One digit per bit pair of the (WIDTH+2)-bit extended multiplier. The
    // extra digit covers the top bit of unsigned operands.
    function automatic int unsigned num_iter(input int unsigned width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// booth_r4_enc -- radix-4 Booth recoder (combinational).
//   window : {b[2i+1], b[2i], b[2i-1]} multiplier bit window
//   sel    : recoded digit as {neg, zero, two}
module booth_r4_enc
    import mult_pkg::*;
(
    input  logic [2:0]  window,
    output booth_sel_t  sel
);

    always_comb begin
        sel = BOOTH_Z;
        unique case (window)
            3'b000, 3'b111: sel = BOOTH_Z;
            3'b001, 3'b010: sel = BOOTH_P1;
            3'b011:         sel = BOOTH_P2;
            3'b100:         sel = BOOTH_M2;
            3'b101, 3'b110: sel = BOOTH_M1;
            default:        sel = BOOTH_Z;
        endcase
    end

endmodule

// File: rtl/booth_r4_multiplier.sv
// booth_r4_multiplier -- iterative radix-4 Booth multiplier, signed/unsigned.
// Retires two multiplier bits per cycle; fixed latency of WIDTH/2+1 cycles.
// WIDTH must be even and >= 4.
//   clk, reset_n  : clock, asynchronous active-low reset
//   op_start      : start request, sampled only in IDLE
//   op_clear      : synchronous abort/clear, wins over op_start in any state
//   signed_mode   : 1 = two's complement operands, 0 = unsigned
//   multiplier    : operand B, latched with op_start
//   multiplicand  : operand A, latched with op_start
//   op_busy       : high while iterating
//   op_done       : high once the product is ready, held until op_clear
//   result        : 2*WIDTH-bit product, valid while op_done
module booth_r4_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               op_start,
    input  logic               op_clear,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic               op_busy,
    output logic               op_done,
    output logic [2*WIDTH-1:0] result
);

    localparam int N     = num_iter(WIDTH);
    localparam int CNT_W = $clog2(N + 1);
    localparam int ACC_W = 2 * WIDTH + 4;
    localparam int RW    = 2 * WIDTH;
    localparam int MB_W  = WIDTH + 3;   // extended multiplier plus b[-1]
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [MB_W-1:0]    mplier_sh;  // window always sits in bits [2:0]
    logic [ACC_W-1:0]   mcand_sh;   // extended multiplicand pre-shifted by 2i
    logic [ACC_W-1:0]   acc;

    logic               a_sign, b_sign;
    logic [ACC_W-1:0]   a_ext;
    logic [MB_W-1:0]    b_ext;
    booth_sel_t         sel;
    logic [ACC_W-1:0]   mag, pp, acc_next;

    assign a_sign = signed_mode & multiplicand[WIDTH-1];
    assign b_sign = signed_mode & multiplier[WIDTH-1];
    assign a_ext  = {{(ACC_W - WIDTH){a_sign}}, multiplicand};
    // Two extension bits above, the implicit b[-1] = 0 below.
    assign b_ext  = {{2{b_sign}}, multiplier, 1'b0};

    booth_r4_enc u_enc (
        .window (mplier_sh[2:0]),
        .sel    (sel)
    );

    // Accumulator arithmetic wraps at ACC_W bits; only the low 2*WIDTH bits
    // are kept, and those are exact modulo 2^(2*WIDTH) in both modes.
    always_comb begin
        mag      = sel.two ? {mcand_sh[ACC_W-2:0], 1'b0} : mcand_sh;
        pp       = '0;
        if (!sel.zero)
            pp = sel.neg ? (~mag + ACC_W'(1)) : mag;
        acc_next = acc + pp;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            count     <= '0;
            mplier_sh <= '0;
            mcand_sh  <= '0;
            acc       <= '0;
            op_busy   <= 1'b0;
            op_done   <= 1'b0;
            result    <= '0;
        end else if (op_clear) begin
            state     <= ST_IDLE;
            count     <= '0;
            mplier_sh <= '0;
            mcand_sh  <= '0;
            acc       <= '0;
            op_busy   <= 1'b0;
            op_done   <= 1'b0;
            result    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (op_start) begin
                        mcand_sh  <= a_ext;
                        mplier_sh <= b_ext;
                        acc       <= '0;
                        count     <= '0;
                        op_busy   <= 1'b1;
                        state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    acc       <= acc_next;
                    mcand_sh  <= {mcand_sh[ACC_W-3:0], 2'b00};
                    mplier_sh <= {2'b00, mplier_sh[MB_W-1:2]};
                    count     <= count + CNT_W'(1);
                    if (count == LAST) begin
                        result  <= acc_next[RW-1:0];
                        op_busy <= 1'b0;
                        op_done <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Held until op_clear; op_start has no effect here.
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Bench for booth_r4_multiplier: a 64-bit and an 8-bit instance share the
// clock and reset. A cycle-level reference (plain multiplication plus a fixed
// latency) is compared against both instances every cycle; directed runs add
// hand-computed literal expectations.
module tb_booth_r4_multiplier;

    logic        clk, reset_n;
    logic        start [2];
    logic        clr   [2];
    logic        sm    [2];
    logic [63:0] a_in  [2];
    logic [63:0] b_in  [2];

    logic         busy_o [2];
    logic         done_o [2];
    logic [127:0] res_o  [2];
    logic [127:0] res64;
    logic [15:0]  res8;

    assign res_o[0] = res64;
    assign res_o[1] = {112'd0, res8};

    int n_cmp = 0;
    int n_bad = 0;

    booth_r4_multiplier #(.WIDTH(64)) dut64 (
        .clk          (clk),
        .reset_n      (reset_n),
        .op_start     (start[0]),
        .op_clear     (clr[0]),
        .signed_mode  (sm[0]),
        .multiplier   (b_in[0]),
        .multiplicand (a_in[0]),
        .op_busy      (busy_o[0]),
        .op_done      (done_o[0]),
        .result       (res64)
    );

    booth_r4_multiplier #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .reset_n      (reset_n),
        .op_start     (start[1]),
        .op_clear     (clr[1]),
        .signed_mode  (sm[1]),
        .multiplier   (b_in[1][7:0]),
        .multiplicand (a_in[1][7:0]),
        .op_busy      (busy_o[1]),
        .op_done      (done_o[1]),
        .result       (res8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int wd(input int k);
        return (k == 0) ? 64 : 8;
    endfunction

    function automatic int nn(input int k);
        return (k == 0) ? 33 : 5;
    endfunction

    // Reference product: extend to 128 bits per mode, multiply, keep 2w bits.
    function automatic logic [127:0] ref_mul(input int w, input logic [63:0] a,
                                             input logic [63:0] b, input logic s);
        logic [127:0] m, ax, bx, p;
        m  = (128'd1 << w) - 128'd1;
        ax = {64'd0, a} & m;
        bx = {64'd0, b} & m;
        if (s && a[w-1]) ax = ax | ~m;
        if (s && b[w-1]) bx = bx | ~m;
        p = ax * bx;
        p = p & ((128'd1 << (2 * w)) - 128'd1);
        return p;
    endfunction

    // ---------------- reference model ----------------
    logic         m_busy [2];
    logic         m_done [2];
    logic [127:0] m_res  [2];
    logic [127:0] m_pend [2];
    int           m_left [2];

    always @(posedge clk or negedge reset_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                m_busy[k] <= 1'b0; m_done[k] <= 1'b0; m_res[k] <= '0;
                m_pend[k] <= '0;   m_left[k] <= 0;
            end else if (clr[k]) begin
                m_busy[k] <= 1'b0; m_done[k] <= 1'b0; m_res[k] <= '0;
                m_left[k] <= 0;
            end else if (!m_busy[k] && !m_done[k]) begin
                if (start[k]) begin
                    m_busy[k] <= 1'b1;
                    m_left[k] <= nn(k);
                    m_pend[k] <= ref_mul(wd(k), a_in[k], b_in[k], sm[k]);
                end
            end else if (m_busy[k]) begin
                if (m_left[k] == 1) begin
                    m_busy[k] <= 1'b0;
                    m_done[k] <= 1'b1;
                    m_res[k]  <= m_pend[k];
                end else begin
                    m_left[k] <= m_left[k] - 1;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (busy_o[k] !== m_busy[k] || done_o[k] !== m_done[k] ||
                    res_o[k] !== m_res[k] || (busy_o[k] && done_o[k])) begin
                    n_bad++;
                    $display("FAIL model_cmp w=%0d t=%0t: busy %b done %b result %h, want busy %b done %b result %h",
                             wd(k), $time, busy_o[k], done_o[k], res_o[k],
                             m_busy[k], m_done[k], m_res[k]);
                end
            end
        end
    end

    // ---------------- directed checks ----------------
    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic do_clear(input int k);
        @(negedge clk); clr[k] = 1'b1;
        @(negedge clk); clr[k] = 1'b0;
    endtask

    // Pulse op_start, wait (bounded) for op_done, check latency and optionally
    // a literal result, then clear.
    task automatic run_op(input int k, input logic [63:0] a, input logic [63:0] b,
                          input logic s, input logic use_lit, input logic [127:0] lit,
                          input string name);
        int cyc;
        @(negedge clk);
        a_in[k] = a; b_in[k] = b; sm[k] = s; start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        cyc = 0;
        while (!done_o[k] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_latency"}, 128'(cyc), 128'(nn(k)));
        if (use_lit) chk({name, "_result"}, res_o[k], lit);
        do_clear(k);
    endtask

    logic [7:0] vals [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h7F, 8'h80,
                              8'h81, 8'hFE, 8'hFF, 8'h55, 8'hAA, 8'h5A};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, time %0t want below 2000000", $time);
        $fatal(1);
    end

    initial begin
        int cyc;
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; clr[k] = 1'b0; sm[k] = 1'b0;
            a_in[k] = '0;    b_in[k] = '0;
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_busy64", 128'(busy_o[0]), 128'd0);
        chk("rst_done64", 128'(done_o[0]), 128'd0);
        chk("rst_res64",  res_o[0], 128'd0);
        chk("rst_done8",  128'(done_o[1]), 128'd0);

        // 64-bit directed products
        run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1,
               128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, "u64_max");
        run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
               128'd1, "s64_m1m1");
        run_op(0, 64'h8000_0000_0000_0000, 64'd2, 1'b1, 1'b1,
               128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, "s64_min_x2");
        run_op(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1,
               128'h4000_0000_0000_0000_0000_0000_0000_0000, "s64_min_sq");

        // 8-bit literals
        run_op(1, 64'h80, 64'h80, 1'b1, 1'b1, 128'h4000, "s8_min_sq");
        run_op(1, 64'hFF, 64'hFF, 1'b0, 1'b1, 128'hFE01, "u8_max");
        run_op(1, 64'hFF, 64'h01, 1'b1, 1'b1, 128'hFFFF, "s8_m1x1");
        run_op(1, 64'h7F, 64'h80, 1'b1, 1'b1, 128'hC080, "s8_maxmin");

        // 8-bit boundary sweep in both modes, checked by the model
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 12; i++)
                for (int j = 0; j < 12; j++)
                    run_op(1, {56'd0, vals[i]}, {56'd0, vals[j]}, s[0], 1'b0, '0, "sweep8");
        for (int r = 0; r < 150; r++)
            run_op(1, 64'($urandom_range(255)), 64'($urandom_range(255)),
                   1'($urandom_range(1)), 1'b0, '0, "rand8");

        // op_clear together with op_start
        @(negedge clk);
        a_in[0] = '1; b_in[0] = '1; sm[0] = 1'b0; start[0] = 1'b1; clr[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0; clr[0] = 1'b0;
        chk("clrstart_busy", 128'(busy_o[0]), 128'd0);
        chk("clrstart_done", 128'(done_o[0]), 128'd0);
        repeat (40) @(negedge clk);
        chk("clrstart_nodone", 128'(done_o[0]), 128'd0);

        // op_clear mid-EXEC at count = 10
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (10) @(negedge clk);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        chk("midclr_busy", 128'(busy_o[0]), 128'd0);
        chk("midclr_done", 128'(done_o[0]), 128'd0);
        chk("midclr_res",  res_o[0], 128'd0);
        repeat (40) @(negedge clk);
        chk("midclr_nodone", 128'(done_o[0]), 128'd0);

        // operands changed and op_start re-pulsed during EXEC and DONE
        @(negedge clk);
        a_in[0] = 64'h1_0000_0001; b_in[0] = 64'd3; sm[0] = 1'b0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        cyc = 0;
        repeat (4) begin @(negedge clk); cyc++; end
        a_in[0] = '1; b_in[0] = '1; sm[0] = 1'b1; start[0] = 1'b1;
        @(negedge clk); cyc++;
        start[0] = 1'b0;
        while (!done_o[0] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("hold_latency", 128'(cyc), 128'd33);
        chk("hold_exec_res", res_o[0], 128'h3_0000_0003);
        a_in[0] = 64'd5; b_in[0] = 64'd5; sm[0] = 1'b0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("hold_done_flag", 128'(done_o[0]), 128'd1);
        chk("hold_done_busy", 128'(busy_o[0]), 128'd0);
        chk("hold_done_res",  res_o[0], 128'h3_0000_0003);
        do_clear(0);
        run_op(0, 64'd7, 64'd6, 1'b0, 1'b1, 128'd42, "rerun");

        // asynchronous reset mid-EXEC, between edges
        @(negedge clk);
        a_in[0] = '1; b_in[0] = '1; sm[0] = 1'b0; start[0] = 1'b1;
        a_in[1] = 64'hFF; b_in[1] = 64'hFF; sm[1] = 1'b0; start[1] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0; start[1] = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy64", 128'(busy_o[0]), 128'd0);
        chk("arst_done64", 128'(done_o[0]), 128'd0);
        chk("arst_res64",  res_o[0], 128'd0);
        chk("arst_busy8",  128'(busy_o[1]), 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(0, 64'd3, 64'd5, 1'b0, 1'b1, 128'd15, "post_rst64");
        run_op(1, 64'd3, 64'd5, 1'b0, 1'b1, 128'd15, "post_rst8");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
